edl_final_switch_pio: RTL and testbench
=======================================

EDL_FINAL_SWITCH_PIO -- requirements
Module: edl_final_switch_pio

Interface
REQ-001 Parameter WIDTH, default 10, number of input bits (slide switches).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive clocks a synchronized bit must differ before it is accepted (1 ms at 50 MHz); legal range 1..2^20.
REQ-003 Parameter EDGE_TYPE, default 2, edge capture type: 0 = rising, 1 = falling, 2 = any.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous switch inputs.
REQ-011 readdata  output  32  registered read data; bits above WIDTH are zero.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 Register map: 0 = DATA (RO, debounced value); 1 = reserved (reads 0, writes ignored); 2 = IRQMASK (RW); 3 = EDGECAP (RO, write-1-to-clear).
REQ-014 Each in_port bit passes through a 2-flop synchronizer before any other logic uses it.
REQ-015 Per bit: counter clears while sync == stable; increments while sync != stable; at DEBOUNCE_CYCLES-th consecutive mismatch, stable <= sync and counter clears.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES clocks leaves stable unchanged; in_port-to-stable latency is 2 + DEBOUNCE_CYCLES clocks.
REQ-017 Edge event per bit = one-cycle pulse on the cycle stable changes, filtered by EDGE_TYPE.
REQ-018 An edge event sets its EDGECAP bit; the bit holds until cleared.
REQ-019 Write (chipselect && !write_n) to address 3 clears every EDGECAP bit whose writedata bit is 1.
REQ-020 Simultaneous edge event and clear on the same bit: the set wins; the bit reads 1.
REQ-021 Write to address 2 loads IRQMASK <= writedata[WIDTH-1:0]; writes to addresses 0 and 1 are ignored.
REQ-022 irq = OR over bits of (EDGECAP & IRQMASK), driven from registers, no combinational path from Avalon inputs.
REQ-023 readdata is registered every cycle from address with fixed read latency 1; no read strobe required; no side effects on read.
REQ-024 Reading EDGECAP in the same cycle as a clear returns the pre-clear value.

Reset
REQ-025 On reset_n low: synchronizers, counters, stable, EDGECAP, IRQMASK and readdata all 0; irq 0.
REQ-026 Reset mid-debounce discards the count; after release, a bit held high produces a rising edge event after 2 + DEBOUNCE_CYCLES clocks (captured, documented behaviour).
REQ-027 Deassertion of reset_n is assumed synchronized externally to clk.

Structure
REQ-028 Shared package edl_final_pkg holds register address constants (ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3) and EDGE_TYPE encodings.
REQ-029 Sub-module edl_final_debounce, single bit (synchronizer + counter + stable flop), instantiated WIDTH times via generate.
REQ-030 Counter width = $clog2(DEBOUNCE_CYCLES+1); no logic depends on clock frequency.

Verification (bench uses WIDTH = 10, DEBOUNCE_CYCLES = 4, EDGE_TYPE = 2)
REQ-031 Drive in_port = 10'h005 held for 10 clocks -> DATA reads 0x005 exactly 6 clocks after change; EDGECAP reads 0x005.
REQ-032 Pulse in_port[3] high for 3 clocks -> DATA and EDGECAP unchanged; pulse for 4 clocks -> both bit 3 set.
REQ-033 Write IRQMASK = 0x001, trigger edge on bit 1 -> irq stays 0; trigger edge on bit 0 -> irq = 1; write EDGECAP = 0x001 -> irq = 0 next cycle.
REQ-034 Clear write to EDGECAP bit 2 on the same cycle bit 2's stable value toggles -> EDGECAP bit 2 reads 1 afterwards.
REQ-035 Assert reset_n low mid-debounce with in_port = 10'h3FF -> all outputs 0; after release, DATA = 0x3FF and EDGECAP = 0x3FF after 6 clocks.
REQ-036 Read address 1 and write to address 0 -> readdata = 0, no register changes.

Source files
------------

// File: rtl/edl_final_pkg.sv
// rtl/edl_final_pkg.sv - shared register map and edge-type encodings for the switch PIO
package edl_final_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Reduce a bit's rise/fall pulses to the single event the EDGE_TYPE parameter asks for.
    function automatic logic edge_select(input int et, input logic rise, input logic fall);
        if (et == int'(EDGE_RISE))
            return rise;
        else if (et == int'(EDGE_FALL))
            return fall;
        else
            return rise | fall;
    endfunction

endpackage

// File: rtl/edl_final_switch_pio_if.sv
// rtl/edl_final_switch_pio_if.sv - Avalon-MM slave bus bundle for the switch PIO
// address/chipselect/write_n/writedata: master -> slave; readdata: slave -> master.
interface edl_final_switch_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata,
                    input  readdata);
    modport slave  (input  address, input  chipselect, input  write_n, input  writedata,
                    output readdata);
endinterface

// File: rtl/edl_final_debounce.sv
// rtl/edl_final_debounce.sv - one-bit synchronizer plus counter-based debouncer
// Ports: clk, reset_n (async active-low), i_async (raw switch), o_stable (accepted level),
//        o_rise / o_fall (one-cycle pulses, high in the cycle o_stable is about to change).
module edl_final_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    // The counter holds the number of mismatches already seen, so the DEBOUNCE_CYCLES-th
    // consecutive mismatch is the one that finds it at DEBOUNCE_CYCLES-1.
    assign w_flip = (r_sync2 != r_stable) && (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_flip &  r_sync2;
    assign o_fall   = w_flip & ~r_sync2;

endmodule

// File: rtl/edl_final_switch_pio.sv
// rtl/edl_final_switch_pio.sv - debounced slide-switch PIO with edge capture and interrupt
// Ports: clk, reset_n (async active-low), bus (Avalon-MM slave: DATA/rsvd/IRQMASK/EDGECAP),
//        in_port (asynchronous switches), irq (level, OR of masked edge captures).
module edl_final_switch_pio
    import edl_final_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    edl_final_switch_pio_if.slave bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_next;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [31:0]      r_readdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        edl_final_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_async  (in_port[g]),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
        assign w_event[g] = edge_select(EDGE_TYPE, w_rise[g], w_fall[g]);
    end

    if (WIDTH < 32) begin : g_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^bus.writedata[31:WIDTH];
    end

    assign w_wr  = bus.chipselect && !bus.write_n;
    assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

    // Clear is applied before the new events are OR-ed in, so a same-cycle edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
            r_irqmask <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_event;
            if (w_wr && bus.address == ADDR_IRQMASK)
                r_irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Read mux samples pre-update register values, so a read racing a clear sees the old bits.
    always_comb begin
        w_rd_next = '0;
        case (bus.address)
            ADDR_DATA:    w_rd_next[WIDTH-1:0] = w_stable;
            ADDR_IRQMASK: w_rd_next[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rd_next[WIDTH-1:0] = r_edgecap;
            default:      w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_readdata <= '0;
        else
            r_readdata <= w_rd_next;
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_edl_final_switch_pio.sv
// tb/tb_edl_final_switch_pio.sv - scoreboard bench for edl_final_switch_pio
module tb_edl_final_switch_pio;
    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    logic         irq;

    edl_final_switch_pio_if bus();

    edl_final_switch_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a switch level is accepted once the input seen two clocks ago has
    // disagreed with the accepted level for D clocks in a row.
    logic [W-1:0] m_lag1, m_lag2, m_stable, m_cap, m_mask;
    int           m_run [W];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lag1 = '0; m_lag2 = '0; m_stable = '0; m_cap = '0; m_mask = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // Called just before a rising edge with the inputs that edge will sample.
    task automatic model_edge();
        exp_t         e;
        logic [W-1:0] ev, clr;
        logic         wr;
        if (!reset_n) begin
            model_reset();
            exp_q.push_back('0);
            return;
        end
        e.rd = '0;
        case (bus.address)
            2'd0: e.rd = 32'(m_stable);
            2'd2: e.rd = 32'(m_mask);
            2'd3: e.rd = 32'(m_cap);
            default: e.rd = '0;
        endcase
        ev = '0;
        for (int i = 0; i < W; i++) begin
            if (m_lag2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    ev[i] = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_stable = m_stable ^ ev;
        wr  = bus.chipselect && !bus.write_n;
        clr = (wr && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (wr && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
        m_lag2 = m_lag1;
        m_lag1 = in_port;
        e.irq = |(m_cap & m_mask);
        exp_q.push_back(e);
    endtask

    function automatic logic will_flip(input int b);
        return (m_lag2[b] != m_stable[b]) && (m_run[b] == D - 1);
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_read(input logic [1:0] a);
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a; bus.writedata = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        step();
        set_read(a);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        set_read(a);
        step();
        v = bus.readdata;
    endtask

    // Monitor: readdata/irq are presented every cycle, one clock after the sampled request.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 2;
            if (bus.readdata !== e.rd) begin
                errors++;
                $display("FAIL sb_readdata @%0t: got %h expected %h", $time, bus.readdata, e.rd);
            end
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL sb_irq @%0t: got %b expected %b", $time, irq, e.irq);
            end
        end
    end

    initial begin
        logic [31:0] v;
        int          guard;
        bit          hit;
        model_reset();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
        @(negedge clk);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        step(); step();
        reset_n = 1'b1;
        set_read(2'd0);
        step(); step(); step();

        // Debounce latency and capture
        in_port = 10'h005;
        for (int i = 0; i < 10; i++) step();
        check("data_005", bus.readdata, 32'h005);
        rd(2'd3, v);
        check("edgecap_005", v, 32'h005);
        wr(2'd3, 32'h3FF);

        // Glitch shorter than D is rejected
        set_read(2'd0);
        in_port = 10'h00D;
        step(); step(); step();
        in_port = 10'h005;
        for (int i = 0; i < 8; i++) step();
        check("glitch3_data", bus.readdata, 32'h005);
        rd(2'd3, v);
        check("glitch3_edgecap", v, 32'h0);

        // Pulse of exactly D is accepted
        set_read(2'd0);
        in_port = 10'h00D;
        for (int i = 0; i < 4; i++) step();
        in_port = 10'h005;
        for (int i = 0; i < 3; i++) step();
        check("pulse4_data", bus.readdata, 32'h00D);
        for (int i = 0; i < 8; i++) step();
        rd(2'd3, v);
        check("pulse4_edgecap", v, 32'h008);
        wr(2'd3, 32'h3FF);

        // Interrupt masking
        wr(2'd2, 32'h001);
        in_port = 10'h007;
        for (int i = 0; i < 8; i++) step();
        check("irq_masked_bit1", 32'(irq), 32'h0);
        in_port = 10'h006;
        for (int i = 0; i < 8; i++) step();
        check("irq_bit0", 32'(irq), 32'h1);
        wr(2'd3, 32'h001);
        check("irq_cleared", 32'(irq), 32'h0);
        wr(2'd3, 32'h3FF);

        // Clear racing a set on bit 2
        in_port = in_port ^ 10'h004;
        hit = 1'b0;
        for (guard = 0; guard < 20 && !hit; guard++) begin
            if (will_flip(2)) begin
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
                bus.address = 2'd3; bus.writedata = 32'h004;
                hit = 1'b1;
            end
            step();
            set_read(2'd3);
        end
        check("race_reached", 32'(hit), 32'h1);
        rd(2'd3, v);
        check("race_set_wins", v & 32'h004, 32'h004);

        // Reserved and read-only addresses
        wr(2'd2, 32'h2AA);
        wr(2'd0, 32'h3FF);
        wr(2'd1, 32'h3FF);
        rd(2'd1, v);
        check("rsvd_reads_0", v, 32'h0);
        rd(2'd2, v);
        check("mask_kept", v, 32'h2AA);

        // Reset in the middle of a debounce
        set_read(2'd0);
        in_port = 10'h3FF;
        step(); step(); step();
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", bus.readdata, 32'h0);
        check("async_reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("post_reset_data", bus.readdata, 32'h3FF);
        rd(2'd3, v);
        check("post_reset_edgecap", v, 32'h3FF);

        // Randomized traffic, checked only through the scoreboard
        for (int c = 0; c < 1500; c++) begin
            int r;
            if ($urandom_range(5, 0) == 0)
                in_port = in_port ^ W'($urandom_range(1023, 1));
            r = $urandom_range(99, 0);
            bus.chipselect = ($urandom_range(9, 0) != 0);
            bus.writedata  = $urandom;
            if (r < 70) begin
                bus.write_n = 1'b1; bus.address = 2'($urandom_range(3, 0));
            end else if (r < 85) begin
                bus.write_n = 1'b0; bus.address = 2'd3;
            end else if (r < 95) begin
                bus.write_n = 1'b0; bus.address = 2'd2;
            end else begin
                bus.write_n = 1'b0; bus.address = 2'($urandom_range(1, 0));
            end
            step();
        end

        set_read(2'd0);
        step();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
